// File: rtl/regfile_write_demux.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_demux
//  Purpose  : Write side of a 32 x N register memory. Buffers (addr, data)
//             requests in a small FIFO and commits one per cycle through a
//             5->32 one-hot decoder. Optional macro ZERO_REG_EN hardwires
//             register 0 to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_demux #(
    parameter int N      = 32,
    parameter int QDEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [4:0]      wr_addr,
    input  logic [N-1:0]    wr_data,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic [31:0]     we_o,
    output logic [2:0]      pend_o,
    output logic [32*N-1:0] regs_o
);

    localparam int         PW    = (QDEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DEPTH = 3'(QDEPTH);

    logic [4:0]    q_addr [QDEPTH];
    logic [N-1:0]  q_data [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [2:0]    count;
    logic          push;
    logic          commit;
    logic [31:0]   dec;
    logic [31:0]   load_en;

    // Ready depends only on the registered count, never on hold_i.
    assign wr_ready = (count < DEPTH);
    assign push     = wr_valid && wr_ready && !flush_i;
    assign commit   = (count != 3'd0) && !hold_i && !flush_i;
    assign pend_o   = count;

    always_comb begin
        dec = 32'd1 << q_addr[head];
    end

`ifdef ZERO_REG_EN
    assign load_en = {dec[31:1], 1'b0};
`else
    assign load_en = dec;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 3'd0;
        end else if (flush_i) begin
            head  <= tail;
            count <= 3'd0;
        end else begin
            if (push)   tail <= tail + PW'(1);
            if (commit) head <= head + PW'(1);
            case ({push, commit})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= wr_addr;
            q_data[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_o <= 32'd0;
        end else begin
            we_o <= commit ? load_en : 32'd0;
        end
    end

    generate
        for (genvar k = 0; k < 32; k++) begin : g_reg
            logic [N-1:0] value;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    value <= '0;
                end else if (commit && load_en[k]) begin
                    value <= q_data[head];
                end
            end
            assign regs_o[k*N +: N] = value;
        end
    endgenerate

endmodule
`default_nettype wire
